l3_tag_arbiter: RTL
===================

Name: l3_tag_arbiter

Overview:
- Owns the single access port of the L3 tag array.
- Arbitrates NUM_REQ lookup requesters, with round-robin fairness among them.
- Gives line-fill tag writes strict priority over lookups.
- Sequences whole-cache flush: drain in-flight lookups, drive the array's flush handshake, report completion.
- Returns per-lookup hit/way responses tagged with requester ID.

Parameters:
- NUM_REQ, 4, number of lookup requesters (power of two, ≥2)
- WAYS, 16, tag array associativity
- INDEX_WIDTH, 12, set index width
- TAG_WIDTH, 22, tag width
- ID_WIDTH, $clog2(NUM_REQ), requester ID width (localparam)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  lookup request valid per requester
- req_ready  out  NUM_REQ  lookup accepted; one-hot or zero
- req_index  in  NUM_REQ*INDEX_WIDTH  packed set index per requester
- req_tag  in  NUM_REQ*TAG_WIDTH  packed compare tag per requester
- fill_valid  in  1  tag write request
- fill_ready  out  1  tag write accepted
- fill_index  in  INDEX_WIDTH  fill set index
- fill_tag  in  TAG_WIDTH  fill tag
- fill_way  in  WAYS  one-hot way to write
- flush_req  in  1  start whole-cache flush (level, sampled in IDLE)
- flush_busy  out  1  flush sequence active
- flush_done  out  1  one-cycle completion pulse
- ta_read_req  out  WAYS  per-way read enable to the tag array
- ta_read_index  out  INDEX_WIDTH  lookup index (same for all ways)
- ta_cmp_tag  out  TAG_WIDTH  compare tag
- ta_write_en  out  1  tag write enable
- ta_write_index  out  INDEX_WIDTH  write index
- ta_write_data  out  TAG_WIDTH  write tag
- ta_write_way  out  WAYS  write way mask
- ta_hit  in  WAYS  per-way hit from the array, valid one cycle after the read
- ta_cache_flush  out  1  flush start pulse
- ta_flush_done  in  1  array flush complete pulse
- rsp_valid  out  1  lookup response valid
- rsp_id  out  ID_WIDTH  requester ID of the response
- rsp_hit  out  1  OR of ta_hit
- rsp_way  out  WAYS  ta_hit passed through

Behaviour:
- Reset: all outputs 0; round-robin pointer 0; FSM in IDLE.
- Reset mid-flush aborts the flush with no flush_done.
- Per-cycle priority, only when FSM is IDLE:
  - A fill wins if fill_valid: fill_ready=1, ta_write_en=1, ta_write_* = fill_*.
  - Otherwise one lookup is granted: the first requester with req_valid, scanning from rr_ptr upward with wrap.
- Lookup grant: req_ready[g]=1, ta_read_req=all-ones, ta_read_index/ta_cmp_tag = requester g fields. Then rr_ptr <= (g+1) mod NUM_REQ.
- rr_ptr is unchanged on fill cycles and idle cycles.
- Response latency is exactly 1:
  - rsp_valid and rsp_id are registered from the grant.
  - rsp_hit and rsp_way are combinational from ta_hit in that next cycle.
- Back-to-back lookups are sustained, one per cycle.
- A fill in cycle T followed by a lookup of the same index in T+1 must observe the new tag; no extra bubble is inserted.
- A fill and lookups in the same cycle: the fill goes and all req_ready stay 0.
- FSM states:
  - IDLE: flush_req=1 moves to DRAIN; no grant is issued in that cycle.
  - DRAIN: no grants. Once no rsp is pending (rsp_valid of the last grant has retired), assert ta_cache_flush for one cycle and move to FLUSH.
  - FLUSH: wait for ta_flush_done, then move to DONE.
  - DONE: flush_done=1 for one cycle, then move to IDLE.
- flush_busy = state in {DRAIN, FLUSH, DONE}.
- While flush_busy, fill_ready=0 and req_ready=0.
- flush_req while busy is ignored. If flush_req is still high on return to IDLE, a new flush starts.
- ta_flush_done outside FLUSH is ignored.

Optional Feature:
- Macro: L3_TAG_ARB_PERF_EN.
- Enabled: adds outputs perf_lookup_cnt[31:0] (increments per lookup grant) and perf_hit_cnt[31:0] (increments per rsp_valid with rsp_hit).
  - Both saturate at 32'hFFFF_FFFF, reset to 0, and clear on flush_done.
- Disabled: the ports and counters are absent.

Decomposition:
- Package l3_tag_ctrl_pkg holds:
  - flush_state_e enum (IDLE, DRAIN, FLUSH, DONE)
  - default WAYS, INDEX_WIDTH and TAG_WIDTH localparams
- Sub-module l3_rr_arbiter: NUM_REQ-wide round-robin with a grant-enable input and a one-hot grant output, reused elsewhere in L3.

Test Plan:
- All 4 requesters valid continuously for 8 cycles → grants 0,1,2,3,0,1,2,3; rsp_id follows, one cycle later.
- Fill (index 0x05A, tag 0x12345, way 0x0004), then req0 lookup index 0x05A tag 0x12345 next cycle → rsp_hit=1, rsp_way=0x0004.
- fill_valid and req_valid=4'b1111 in the same cycle → fill_ready=1, req_ready=0; next cycle grants requester at rr_ptr; rr_ptr unchanged across the fill.
- Lookup granted at T, flush_req at T+1 → rsp at T+1 still delivered; ta_cache_flush at T+2; ta_flush_done at T+10 → flush_done at T+11, flush_busy high T+1..T+11.
- rst_n low during FLUSH → all outputs 0 immediately, no flush_done; lookups resume after deassert, starting at requester 0.
- With L3_TAG_ARB_PERF_EN: 10 lookups, 6 hits → perf_lookup_cnt=10, perf_hit_cnt=6; both cleared by flush_done.

Source files
------------

// File: rtl/l3_tag_ctrl_pkg.sv
// Shared types and default geometry for the L3 tag-array control blocks.
package l3_tag_ctrl_pkg;

    localparam int unsigned DEF_WAYS        = 16;
    localparam int unsigned DEF_INDEX_WIDTH = 12;
    localparam int unsigned DEF_TAG_WIDTH   = 22;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } flush_state_e;

endpackage

// File: rtl/l3_rr_arbiter.sv
// NUM_REQ-wide round-robin arbiter: scans upward from rr_ptr with wrap and
// advances the pointer past the winner only on cycles where a grant is issued.
module l3_rr_arbiter #(
    parameter int unsigned  NUM_REQ  = 4,
    localparam int unsigned ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_REQ-1:0]  req,
    input  logic                en,
    output logic [NUM_REQ-1:0]  gnt,
    output logic [ID_WIDTH-1:0] gnt_id,
    output logic                gnt_valid
);

    logic [ID_WIDTH-1:0] rr_ptr;
    logic [ID_WIDTH-1:0] cand;

    // NUM_REQ is a power of two, so index arithmetic wraps naturally.
    always_comb begin
        gnt       = '0;
        gnt_id    = '0;
        gnt_valid = 1'b0;
        cand      = '0;
        if (en) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                cand = rr_ptr + ID_WIDTH'(i);
                if (!gnt_valid && req[cand]) begin
                    gnt_valid = 1'b1;
                    gnt_id    = cand;
                end
            end
        end
        gnt[gnt_id] = gnt_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (gnt_valid) begin
            rr_ptr <= gnt_id + ID_WIDTH'(1);
        end
    end

endmodule

// File: rtl/l3_tag_arbiter.sv
// Single-port L3 tag array arbiter: fills over round-robin lookups, plus the
// whole-cache flush sequencer. Define L3_TAG_ARB_PERF_EN for perf counters.
module l3_tag_arbiter
    import l3_tag_ctrl_pkg::*;
#(
    parameter int unsigned  NUM_REQ     = 4,
    parameter int unsigned  WAYS        = DEF_WAYS,
    parameter int unsigned  INDEX_WIDTH = DEF_INDEX_WIDTH,
    parameter int unsigned  TAG_WIDTH   = DEF_TAG_WIDTH,
    localparam int unsigned ID_WIDTH    = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst_n,
`ifdef L3_TAG_ARB_PERF_EN
    output logic [31:0]                    perf_lookup_cnt,
    output logic [31:0]                    perf_hit_cnt,
`endif
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*INDEX_WIDTH-1:0] req_index,
    input  logic [NUM_REQ*TAG_WIDTH-1:0]   req_tag,
    input  logic                           fill_valid,
    output logic                           fill_ready,
    input  logic [INDEX_WIDTH-1:0]         fill_index,
    input  logic [TAG_WIDTH-1:0]           fill_tag,
    input  logic [WAYS-1:0]                fill_way,
    input  logic                           flush_req,
    output logic                           flush_busy,
    output logic                           flush_done,
    output logic [WAYS-1:0]                ta_read_req,
    output logic [INDEX_WIDTH-1:0]         ta_read_index,
    output logic [TAG_WIDTH-1:0]           ta_cmp_tag,
    output logic                           ta_write_en,
    output logic [INDEX_WIDTH-1:0]         ta_write_index,
    output logic [TAG_WIDTH-1:0]           ta_write_data,
    output logic [WAYS-1:0]                ta_write_way,
    input  logic [WAYS-1:0]                ta_hit,
    output logic                           ta_cache_flush,
    input  logic                           ta_flush_done,
    output logic                           rsp_valid,
    output logic [ID_WIDTH-1:0]            rsp_id,
    output logic                           rsp_hit,
    output logic [WAYS-1:0]                rsp_way
);

    flush_state_e        state_q;
    flush_state_e        state_d;
    logic                cache_flush_c;
    logic                idle;
    logic                accept_en;
    logic                fill_go;
    logic                lookup_en;
    logic [NUM_REQ-1:0]  gnt;
    logic [ID_WIDTH-1:0] gnt_id;
    logic                gnt_any;
    logic                rsp_valid_q;
    logic [ID_WIDTH-1:0] rsp_id_q;

    // The cycle that samples flush_req already counts as busy and issues nothing.
    assign idle      = (state_q == IDLE);
    assign accept_en = rst_n && idle && !flush_req;
    assign fill_go   = accept_en && fill_valid;
    assign lookup_en = accept_en && !fill_valid;

    l3_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_valid),
        .en        (lookup_en),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cache_flush_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush_req) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!rsp_valid_q) begin
                    cache_flush_c = 1'b1;
                    state_d       = FLUSH;
                end
            end
            FLUSH: begin
                if (ta_flush_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Response is the registered grant; hit data is the array's next-cycle result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
        end else begin
            rsp_valid_q <= gnt_any;
            rsp_id_q    <= gnt_any ? gnt_id : '0;
        end
    end

    assign req_ready      = gnt;
    assign ta_read_req    = {WAYS{gnt_any}};
    assign ta_read_index  = gnt_any ? req_index[32'(gnt_id) * INDEX_WIDTH +: INDEX_WIDTH] : '0;
    assign ta_cmp_tag     = gnt_any ? req_tag[32'(gnt_id) * TAG_WIDTH +: TAG_WIDTH] : '0;

    assign fill_ready     = fill_go;
    assign ta_write_en    = fill_go;
    assign ta_write_index = fill_go ? fill_index : '0;
    assign ta_write_data  = fill_go ? fill_tag : '0;
    assign ta_write_way   = fill_go ? fill_way : '0;

    assign flush_busy     = rst_n && (!idle || flush_req);
    assign flush_done     = (state_q == DONE);
    assign ta_cache_flush = cache_flush_c;

    assign rsp_valid      = rsp_valid_q;
    assign rsp_id         = rsp_id_q;
    assign rsp_hit        = rsp_valid_q && (|ta_hit);
    assign rsp_way        = rsp_valid_q ? ta_hit : '0;

`ifdef L3_TAG_ARB_PERF_EN
    // Saturating event counters, cleared when a flush completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_lookup_cnt <= '0;
            perf_hit_cnt    <= '0;
        end else if (state_q == DONE) begin
            perf_lookup_cnt <= '0;
            perf_hit_cnt    <= '0;
        end else begin
            if (gnt_any && (perf_lookup_cnt != 32'hFFFF_FFFF)) begin
                perf_lookup_cnt <= perf_lookup_cnt + 32'd1;
            end
            if (rsp_hit && (perf_hit_cnt != 32'hFFFF_FFFF)) begin
                perf_hit_cnt <= perf_hit_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
